dcache_fill_ctrl: RTL and testbench
===================================

Name: dcache_fill_ctrl

Overview:
Fill/writeback sequencer that sits directly below each dcache line. On a miss it writes the old dirty line back to memory, then refills the line word by word. It drives the line's flush_mode/flush_write/flush_addr/line_in/line_in_valid/flush_dirty inputs and runs one word at a time on a req/ack memory port.

Parameters:
DATABITS, 32, memory/cache word width
ADDRBITS, 32, byte address width
CACHEADDRBITS, 5, word index bits per line
LSBITS, 2, byte-offset bits per word
CACHESIZE, 2**CACHEADDRBITS, words per line
TIMEOUTBITS, 10, ack watchdog width (feature only)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
fill_req  in  1  start pulse; sampled only in IDLE
fill_addr  in  ADDRBITS  new line base; index/offset bits ignored
wb_addr  in  ADDRBITS  old line base (line's mem_addr)
wb_dirty  in  1  old line dirty; 1 = writeback required
req_dirty  in  1  value forwarded as flush_dirty at commit
busy  out  1  high in any state except IDLE
fill_done  out  1  one-cycle pulse at end of COMMIT
fill_error  out  1  sticky abort flag (feature only, else tied 0)
wb_rd_addr  out  CACHEADDRBITS  cache word index for the writeback read
wb_rd_data  in  DATABITS  line_out; valid 1 cycle after wb_rd_addr
flush_mode  out  1  to line
flush_write  out  1  to line
flush_addr  out  CACHEADDRBITS  to line
flush_dirty  out  1  to line
line_in  out  DATABITS  to line
line_in_valid  out  1  to line
mem_addr  out  ADDRBITS  word address; low LSBITS bits are 0
mem_wdata  out  DATABITS  write data
mem_wrreq  out  1  write request; held until mem_ack
mem_rdreq  out  1  read request; held until mem_ack
mem_rdata  in  DATABITS  read data; valid when mem_ack and mem_rdreq
mem_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset: state IDLE. Word counter 0. All outputs 0, including the buses.
- States: IDLE, WB_RD, WB_WR, FILL, COMMIT.
- IDLE: if fill_req, latch fill_addr, wb_addr, wb_dirty and req_dirty, and clear the counter. If wb_dirty, go to WB_RD; otherwise go to FILL.
- WB_RD: wb_rd_addr = counter for 1 cycle, then go to WB_WR.
- WB_WR: register wb_rd_data into mem_wdata on entry.
  - mem_wrreq = 1 and mem_addr = {wb_addr[MSBs], counter, LSBITS'b0}.
  - On mem_ack: drop mem_wrreq in the same edge. If counter == CACHESIZE-1, clear the counter and go to FILL; else increment the counter and go to WB_RD.
  - Cost: 2 cycles minimum per word.
- FILL: mem_rdreq = 1 and mem_addr = {fill_addr[MSBs], counter, LSBITS'b0}.
  - On mem_ack, the next cycle carries a one-cycle pulse: line_in = mem_rdata, line_in_valid = 1, flush_write = 1, flush_addr = counter, flush_mode = 0.
  - mem_rdreq is low during the pulse cycle; the next request follows it.
  - After the word CACHESIZE-1 pulse, go to COMMIT.
- COMMIT: for one cycle, flush_mode = 1, flush_write = 1, flush_dirty = latched req_dirty, line_in_valid = 0. This updates the line tag and clears r_init.
  - fill_done pulses in the same cycle; return to IDLE.
- Counter is CACHEADDRBITS wide. Wrap from CACHESIZE-1 to 0 is the terminal condition; no overflow.
- fill_req while busy: ignored, with no queueing.
- mem_ack while neither request is asserted: ignored.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The partially filled line stays tagged old/invalid because COMMIT never occurred.
- mem_wrreq and mem_rdreq are never high together.

Optional Feature:
DCACHE_FILL_TIMEOUT_EN
- Defined: a TIMEOUTBITS watchdog counts cycles that mem_wrreq/mem_rdreq stays high without mem_ack, and clears on ack.
  - At all-ones: drop the request, set fill_error, skip COMMIT, and go to IDLE. fill_done is not pulsed.
  - fill_error clears on the next accepted fill_req or on reset.
- Undefined: no watchdog; the block waits for mem_ack indefinitely; fill_error tied 0.

Test Plan:
1. Clean miss: fill_req with wb_dirty=0, fill_addr=0x00001280, ack 1 cycle after each rdreq -> no mem_wrreq; 32 reads at 0x1280..0x12FC; 32 line_in_valid pulses with flush_addr 0..31; then COMMIT with flush_mode=flush_write=1; fill_done asserted.
2. Dirty miss: wb_dirty=1, wb_addr=0x00000400, wb_rd_data = index*3 -> 32 writes to 0x400..0x47C with mem_wdata=0,3,...,93, all before the first mem_rdreq; then the normal fill.
3. Back-pressure: mem_ack delayed 5 cycles on word 7 -> mem_addr and mem_wdata stable while the request is held; no duplicate writes; counter not advanced.
4. fill_req pulsed during FILL -> ignored; exactly one fill_done.
5. reset_n low during WB_WR word 10 -> all outputs 0 asynchronously; after release, busy=0 and a new fill_req starts at word 0.
6. (DCACHE_FILL_TIMEOUT_EN) mem_ack never asserted -> after 1023 cycles mem_rdreq drops, fill_error=1, no COMMIT; the next fill_req clears fill_error.

Source files
------------

// File: rtl/dcache_fill_ctrl.sv
// ---------------------------------------------------------------------------------------------
// dcache_fill_ctrl
//
// Miss sequencer placed below a dcache line. On fill_req it optionally writes the old dirty
// line back to memory one word at a time, refills the line word by word, then commits the new
// tag for one cycle.
//
// Ports:
//   clk, reset_n                  clock (rising edge), asynchronous active-low reset
//   fill_req, fill_addr           start pulse (IDLE only) and new line base address
//   wb_addr, wb_dirty, req_dirty  old line base, writeback needed, dirty bit to commit
//   busy, fill_done, fill_error   status: not idle, end-of-commit pulse, sticky abort flag
//   wb_rd_addr, wb_rd_data        word index into the old line and its read data
//   flush_mode, flush_write,
//   flush_addr, flush_dirty,
//   line_in, line_in_valid        write-side controls into the cache line
//   mem_addr, mem_wdata,
//   mem_wrreq, mem_rdreq,
//   mem_rdata, mem_ack            single-word req/ack memory port
//
// Build option:
//   DCACHE_FILL_TIMEOUT_EN  adds a TIMEOUTBITS ack watchdog that aborts the sequence and sets
//                           fill_error; without it fill_error is tied low.
// ---------------------------------------------------------------------------------------------
module dcache_fill_ctrl #(
    parameter int unsigned DATABITS      = 32,
    parameter int unsigned ADDRBITS      = 32,
    parameter int unsigned CACHEADDRBITS = 5,
    parameter int unsigned LSBITS        = 2,
    parameter int unsigned CACHESIZE     = 2 ** CACHEADDRBITS,
    parameter int unsigned TIMEOUTBITS   = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fill_req,
    input  logic [ADDRBITS-1:0]      fill_addr,
    input  logic [ADDRBITS-1:0]      wb_addr,
    input  logic                     wb_dirty,
    input  logic                     req_dirty,
    output logic                     busy,
    output logic                     fill_done,
    output logic                     fill_error,
    output logic [CACHEADDRBITS-1:0] wb_rd_addr,
    input  logic [DATABITS-1:0]      wb_rd_data,
    output logic                     flush_mode,
    output logic                     flush_write,
    output logic [CACHEADDRBITS-1:0] flush_addr,
    output logic                     flush_dirty,
    output logic [DATABITS-1:0]      line_in,
    output logic                     line_in_valid,
    output logic [ADDRBITS-1:0]      mem_addr,
    output logic [DATABITS-1:0]      mem_wdata,
    output logic                     mem_wrreq,
    output logic                     mem_rdreq,
    input  logic [DATABITS-1:0]      mem_rdata,
    input  logic                     mem_ack
);

    localparam int unsigned TagBits = ADDRBITS - CACHEADDRBITS - LSBITS;
    localparam logic [CACHEADDRBITS-1:0] LastIdx = CACHEADDRBITS'(CACHESIZE - 1);

    typedef enum logic [2:0] {StIdle, StWbRd, StWbWr, StFill, StCommit} state_e;

    state_e                   state_q, state_d;
    logic [CACHEADDRBITS-1:0] cnt_q, cnt_d;
    logic [TagBits-1:0]       fill_base_q, fill_base_d;
    logic [TagBits-1:0]       wb_base_q, wb_base_d;
    logic                     req_dirty_q, req_dirty_d;
    logic [DATABITS-1:0]      wdata_q, wdata_d;
    logic [DATABITS-1:0]      rdata_q, rdata_d;
    // High for the single line-write cycle that follows each read ack.
    logic                     pulse_q, pulse_d;

    logic req_active;
    logic timeout_hit;
    logic ack_ok;

    // Index/offset bits of the incoming bases are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fill_addr[CACHEADDRBITS+LSBITS-1:0],
                                wb_addr[CACHEADDRBITS+LSBITS-1:0]};

    // A memory request is outstanding in WB_WR and in FILL outside the line-write cycle.
    assign req_active = (state_q == StWbWr) || ((state_q == StFill) && !pulse_q);

`ifdef DCACHE_FILL_TIMEOUT_EN
    logic [TIMEOUTBITS-1:0] wd_q, wd_d;
    logic                   error_q, error_d;

    assign timeout_hit = req_active && (wd_q == {TIMEOUTBITS{1'b1}});
    assign wd_d        = (req_active && !mem_ack && !timeout_hit) ? wd_q + 1'b1 : '0;
    assign fill_error  = error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end
`else
    localparam int unsigned unused_timeout_bits = TIMEOUTBITS;
    assign timeout_hit = 1'b0;
    assign fill_error  = 1'b0;
`endif

    // The request is withdrawn in the abort cycle, so an ack arriving then is not a completion.
    assign ack_ok = mem_ack && !timeout_hit;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            fill_base_q <= '0;
            wb_base_q   <= '0;
            req_dirty_q <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            pulse_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            fill_base_q <= fill_base_d;
            wb_base_q   <= wb_base_d;
            req_dirty_q <= req_dirty_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            pulse_q     <= pulse_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_base_d = fill_base_q;
        wb_base_d   = wb_base_q;
        req_dirty_d = req_dirty_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        pulse_d     = 1'b0;
`ifdef DCACHE_FILL_TIMEOUT_EN
        error_d     = error_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (fill_req) begin
                    fill_base_d = fill_addr[ADDRBITS-1:CACHEADDRBITS+LSBITS];
                    wb_base_d   = wb_addr[ADDRBITS-1:CACHEADDRBITS+LSBITS];
                    req_dirty_d = req_dirty;
                    cnt_d       = '0;
`ifdef DCACHE_FILL_TIMEOUT_EN
                    error_d     = 1'b0;
`endif
                    state_d     = wb_dirty ? StWbRd : StFill;
                end
            end
            StWbRd: begin
                // Capture the old word as WB_WR is entered so mem_wdata is valid immediately.
                wdata_d = wb_rd_data;
                state_d = StWbWr;
            end
            StWbWr: begin
                if (ack_ok) begin
                    if (cnt_q == LastIdx) begin
                        cnt_d   = '0;
                        state_d = StFill;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StWbRd;
                    end
                end
            end
            StFill: begin
                if (pulse_q) begin
                    if (cnt_q == LastIdx) begin
                        cnt_d   = '0;
                        state_d = StCommit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (ack_ok) begin
                    rdata_d = mem_rdata;
                    pulse_d = 1'b1;
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Watchdog abort: leave the line untouched (no COMMIT) and flag the error.
        if (timeout_hit) begin
            state_d = StIdle;
            cnt_d   = '0;
            pulse_d = 1'b0;
`ifdef DCACHE_FILL_TIMEOUT_EN
            error_d = 1'b1;
`endif
        end
    end

    // Outputs: everything idles at zero so reset drives all buses low.
    always_comb begin
        busy          = 1'b0;
        fill_done     = 1'b0;
        wb_rd_addr    = '0;
        flush_mode    = 1'b0;
        flush_write   = 1'b0;
        flush_addr    = '0;
        flush_dirty   = 1'b0;
        line_in       = '0;
        line_in_valid = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wrreq     = 1'b0;
        mem_rdreq     = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StWbRd: begin
                busy       = 1'b1;
                wb_rd_addr = cnt_q;
            end
            StWbWr: begin
                busy      = 1'b1;
                mem_wrreq = !timeout_hit;
                mem_addr  = {wb_base_q, cnt_q, {LSBITS{1'b0}}};
                mem_wdata = wdata_q;
            end
            StFill: begin
                busy = 1'b1;
                if (pulse_q) begin
                    line_in       = rdata_q;
                    line_in_valid = 1'b1;
                    flush_write   = 1'b1;
                    flush_addr    = cnt_q;
                end else begin
                    mem_rdreq = !timeout_hit;
                    mem_addr  = {fill_base_q, cnt_q, {LSBITS{1'b0}}};
                end
            end
            StCommit: begin
                busy        = 1'b1;
                fill_done   = 1'b1;
                flush_mode  = 1'b1;
                flush_write = 1'b1;
                flush_dirty = req_dirty_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
module tb_dcache_fill_ctrl;

    localparam int NW = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fill_req = 1'b0;
    logic [31:0] fill_addr = '0;
    logic [31:0] wb_addr = '0;
    logic        wb_dirty = 1'b0;
    logic        req_dirty = 1'b0;
    logic        busy, fill_done, fill_error;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        flush_mode, flush_write, flush_dirty, line_in_valid;
    logic [4:0]  flush_addr;
    logic [31:0] line_in, mem_addr, mem_wdata;
    logic        mem_wrreq, mem_rdreq;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    dcache_fill_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fill_req      (fill_req),
        .fill_addr     (fill_addr),
        .wb_addr       (wb_addr),
        .wb_dirty      (wb_dirty),
        .req_dirty     (req_dirty),
        .busy          (busy),
        .fill_done     (fill_done),
        .fill_error    (fill_error),
        .wb_rd_addr    (wb_rd_addr),
        .wb_rd_data    (wb_rd_data),
        .flush_mode    (flush_mode),
        .flush_write   (flush_write),
        .flush_addr    (flush_addr),
        .flush_dirty   (flush_dirty),
        .line_in       (line_in),
        .line_in_valid (line_in_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wrreq     (mem_wrreq),
        .mem_rdreq     (mem_rdreq),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    always #5 clk = ~clk;

    // Old line contents: word i holds i*3.
    assign wb_rd_data = 32'(wb_rd_addr) * 32'd3;

    typedef struct {
        logic        dirty;
        logic [31:0] faddr;
        logic [31:0] waddr;
        logic        rdirty;
        int          dly_word;
        int          dly;
        bit          spur;
        bit          poke;
        int          exp_wr;
        logic [31:0] exp_wbase;
        logic [31:0] exp_fbase;
    } vec_t;

    vec_t vecs[4];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dpat(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic check_all_zero(input string name);
        logic any;
        any = |{busy, fill_done, fill_error, wb_rd_addr, flush_mode, flush_write, flush_addr,
                flush_dirty, line_in, line_in_valid, mem_addr, mem_wdata, mem_wrreq, mem_rdreq};
        check(name, 64'(any), 64'd0);
    endtask

    // One complete miss with an in-bench memory responder and line monitor.
    task automatic run_txn(input vec_t v, input int id);
        int wr_n = 0, rd_n = 0, pulse_n = 0, done_n = 0, commit_n = 0;
        int hold = 0, cyc = 0, lat, extra;
        bit do_poke;
        @(negedge clk);
        fill_req  = 1'b1;
        fill_addr = v.faddr;
        wb_addr   = v.waddr;
        wb_dirty  = v.dirty;
        req_dirty = v.rdirty;
        @(negedge clk);
        fill_req  = 1'b0;
        // Scramble inputs to prove they were latched.
        fill_addr = 32'hDEAD_BEEF;
        wb_addr   = 32'hFACE_CAFE;
        wb_dirty  = ~v.dirty;
        req_dirty = ~v.rdirty;
        while (done_n == 0 && cyc < 4000) begin
            mem_ack   = 1'b0;
            fill_req  = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            do_poke   = v.poke && mem_rdreq && rd_n == 5 && hold == 0;
            check($sformatf("t%0d req_exclusive", id), 64'(mem_wrreq & mem_rdreq), 64'd0);
            if (mem_wrreq) begin
                check($sformatf("t%0d wr_addr[%0d]", id, wr_n), 64'(mem_addr),
                      64'(v.exp_wbase + 32'(wr_n) * 4));
                check($sformatf("t%0d wr_data[%0d]", id, wr_n), 64'(mem_wdata),
                      64'(32'(wr_n) * 3));
                if (hold == 0) check($sformatf("t%0d wr_before_rd", id), 64'(rd_n), 64'd0);
                lat = (wr_n == v.dly_word) ? v.dly : 1;
                if (hold >= lat) begin
                    mem_ack = 1'b1;
                    wr_n++;
                    hold = 0;
                end else begin
                    hold++;
                end
            end else if (mem_rdreq) begin
                check($sformatf("t%0d rd_addr[%0d]", id, rd_n), 64'(mem_addr),
                      64'(v.exp_fbase + 32'(rd_n) * 4));
                lat = (rd_n == v.dly_word) ? v.dly : 1;
                if (hold >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = dpat(rd_n);
                    rd_n++;
                    hold = 0;
                end else begin
                    hold++;
                end
            end else if (v.spur) begin
                mem_ack = 1'b1;
            end
            if (line_in_valid) begin
                check($sformatf("t%0d pulse_addr[%0d]", id, pulse_n), 64'(flush_addr),
                      64'(pulse_n));
                check($sformatf("t%0d line_in[%0d]", id, pulse_n), 64'(line_in),
                      64'(dpat(pulse_n)));
                check($sformatf("t%0d pulse_ctl[%0d]", id, pulse_n),
                      64'({flush_write, flush_mode}), 64'b10);
                check($sformatf("t%0d pulse_after_ack", id), 64'(rd_n), 64'(pulse_n + 1));
                pulse_n++;
            end
            if (flush_mode) begin
                commit_n++;
                check($sformatf("t%0d commit_ctl", id),
                      64'({flush_write, flush_dirty, line_in_valid}), 64'({1'b1, v.rdirty, 1'b0}));
                check($sformatf("t%0d commit_after_fill", id), 64'(pulse_n), 64'(NW));
            end
            if (fill_done) begin
                done_n++;
                check($sformatf("t%0d done_with_commit", id), 64'(flush_mode), 64'd1);
            end
            if (do_poke) begin
                fill_req  = 1'b1;
                fill_addr = 32'h0000_0000;
                wb_dirty  = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        mem_ack  = 1'b0;
        fill_req = 1'b0;
        check($sformatf("t%0d done_count", id), 64'(done_n), 64'd1);
        check($sformatf("t%0d commit_count", id), 64'(commit_n), 64'd1);
        check($sformatf("t%0d writes", id), 64'(wr_n), 64'(v.exp_wr));
        check($sformatf("t%0d reads", id), 64'(rd_n), 64'(NW));
        check($sformatf("t%0d pulses", id), 64'(pulse_n), 64'(NW));
        extra = 0;
        repeat (20) begin
            extra += int'(busy) + int'(fill_done) + int'(mem_rdreq) + int'(mem_wrreq);
            @(negedge clk);
        end
        check($sformatf("t%0d quiet_after", id), 64'(extra), 64'd0);
    endtask

    initial begin
        int cyc;
        bit hit;
        vecs[0] = '{dirty: 1'b0, faddr: 32'h0000_1280, waddr: 32'h0, rdirty: 1'b0,
                    dly_word: -1, dly: 0, spur: 1'b0, poke: 1'b0,
                    exp_wr: 0, exp_wbase: 32'h0, exp_fbase: 32'h0000_1280};
        vecs[1] = '{dirty: 1'b1, faddr: 32'h0000_2000, waddr: 32'h0000_0400, rdirty: 1'b1,
                    dly_word: -1, dly: 0, spur: 1'b0, poke: 1'b0,
                    exp_wr: 32, exp_wbase: 32'h0000_0400, exp_fbase: 32'h0000_2000};
        vecs[2] = '{dirty: 1'b1, faddr: 32'h1234_5678, waddr: 32'h0000_047F, rdirty: 1'b0,
                    dly_word: 7, dly: 5, spur: 1'b0, poke: 1'b0,
                    exp_wr: 32, exp_wbase: 32'h0000_0400, exp_fbase: 32'h1234_5600};
        vecs[3] = '{dirty: 1'b0, faddr: 32'hFFFF_FF80, waddr: 32'h0, rdirty: 1'b1,
                    dly_word: -1, dly: 0, spur: 1'b1, poke: 1'b1,
                    exp_wr: 0, exp_wbase: 32'h0, exp_fbase: 32'hFFFF_FF80};

        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        for (int i = 0; i < 4; i++) run_txn(vecs[i], i);

        // Reset while writing back word 10.
        @(negedge clk);
        fill_req  = 1'b1;
        wb_dirty  = 1'b1;
        wb_addr   = 32'h0000_0800;
        fill_addr = 32'h0000_3000;
        @(negedge clk);
        fill_req = 1'b0;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 1000) begin
            mem_ack = 1'b0;
            if (mem_wrreq) begin
                if (mem_addr == 32'h0000_0828) hit = 1'b1;
                else mem_ack = 1'b1;
            end
            if (!hit) begin
                cyc++;
                @(negedge clk);
            end
        end
        check("rst_reached_word10", 64'(hit), 64'd1);
        mem_ack = 1'b0;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("busy_after_reset", 64'(busy), 64'd0);
        run_txn(vecs[1], 4);

`ifdef DCACHE_FILL_TIMEOUT_EN
        begin
            int hi_cnt;
            bit seen_done;
            @(negedge clk);
            fill_req  = 1'b1;
            wb_dirty  = 1'b0;
            fill_addr = 32'h0000_5000;
            @(negedge clk);
            fill_req  = 1'b0;
            hi_cnt    = 0;
            seen_done = 1'b0;
            cyc       = 0;
            while (cyc < 3000 && !(hi_cnt > 0 && !mem_rdreq)) begin
                if (mem_rdreq) hi_cnt++;
                seen_done |= fill_done;
                cyc++;
                @(negedge clk);
            end
            check("to_req_cycles", 64'(hi_cnt), 64'd1023);
            seen_done |= fill_done | flush_mode;
            @(negedge clk);
            check("to_error_set", 64'(fill_error), 64'd1);
            check("to_idle", 64'(busy), 64'd0);
            check("to_no_commit", 64'(seen_done), 64'd0);
            fill_req = 1'b1;
            @(negedge clk);
            fill_req = 1'b0;
            check("to_error_cleared", 64'(fill_error), 64'd0);
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
